// File: rtl/controle_envase_parametrizado.sv
`default_nettype none
//============================================================================
// Module   : controle_envase_parametrizado
// Purpose  : Bottling-line filling/sealing controller. It contains:
//              - a motor / fill / seal state machine with a fill timeout
//              - a bottles-in-dozen counter and a wrapping dozen counter
//              - two-level cork storage: a primary reservoir fed
//                automatically from a secondary buffer, and manual
//                load/unload of the secondary buffer.
//            The block sits between the debounced panel/sensor inputs and
//            the display multiplexer. Its counters feed the BCD encoders.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk          in   1        system clock (already divided)
//   clr          in   1        synchronous active-high reset
//   enable       in   1        start/stop switch, 0 forces IDLE
//   pg           in   1        bottle present at position
//   ch           in   1        bottle full sensor
//   cq           in   1        seal-complete sensor
//   load_req     in   1        one-cycle manual secondary-buffer request
//   load_dir     in   1        1 = add load_qty, 0 = remove load_qty
//   load_qty     in   CORK_W   quantity for the manual operation
//   m            out  1        conveyor motor
//   ev           out  1        fill valve
//   ve           out  1        sealing actuator
//   al           out  1        alarm (no corks or fill timeout)
//   estado       out  3        state code (IDLE=0 MOVE=1 FILL=2 SEAL=3 ALARM=4)
//   corks        out  CORK_W   primary reservoir level
//   secondary    out  CORK_W   secondary buffer level
//   dozens       out  4        bottles in the current dozen, 0..11
//   tens_dozens  out  4        dozen counter, 0..DOZEN_WRAP-1
//   dozen_done   out  1        one-cycle pulse when a dozen completes
//   load_reject  out  1        one-cycle pulse when a manual op is refused
//============================================================================
module controle_envase_parametrizado #(
    parameter int CORK_W       = 7,
    parameter int CORK_MAX     = 99,
    parameter int CORK_MIN     = 5,
    parameter int REFILL_QTY   = 15,
    parameter int DOZEN_WRAP   = 10,
    parameter int TO_W         = 8,
    parameter int FILL_TIMEOUT = 200
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              enable,
    input  logic              pg,
    input  logic              ch,
    input  logic              cq,
    input  logic              load_req,
    input  logic              load_dir,
    input  logic [CORK_W-1:0] load_qty,
    output logic              m,
    output logic              ev,
    output logic              ve,
    output logic              al,
    output logic [2:0]        estado,
    output logic [CORK_W-1:0] corks,
    output logic [CORK_W-1:0] secondary,
    output logic [3:0]        dozens,
    output logic [3:0]        tens_dozens,
    output logic              dozen_done,
    output logic              load_reject
);

    //------------------------------------------------------------------------
    // Constants
    //------------------------------------------------------------------------
    localparam logic [CORK_W-1:0] c_cork_max     = CORK_W'(CORK_MAX);
    localparam logic [CORK_W:0]   c_cork_max_ext = (CORK_W + 1)'(CORK_MAX);
    localparam logic [CORK_W-1:0] c_cork_min     = CORK_W'(CORK_MIN);
    localparam logic [CORK_W-1:0] c_refill_qty   = CORK_W'(REFILL_QTY);
    localparam logic [TO_W-1:0]   c_to_last      = TO_W'(FILL_TIMEOUT - 1);
    localparam logic [3:0]        c_dozen_last   = 4'd11;
    localparam logic [3:0]        c_tens_last    = 4'(DOZEN_WRAP - 1);

    //------------------------------------------------------------------------
    // State encoding
    //------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MOVE  = 3'd1,
        ST_FILL  = 3'd2,
        ST_SEAL  = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Cycles spent in FILL without the full sensor firing.
    logic [TO_W-1:0]   to_q, to_d;

    logic [CORK_W-1:0] corks_q, corks_d;
    logic [CORK_W-1:0] secondary_q, secondary_d;
    logic [3:0]        dozens_q, dozens_d;
    logic [3:0]        tens_q, tens_d;
    logic              dozen_done_q, dozen_done_d;
    logic              load_reject_q, load_reject_d;

    logic              m_q, m_d;
    logic              ev_q, ev_d;
    logic              ve_q, ve_d;
    logic              al_q, al_d;
    logic [2:0]        estado_q, estado_d;

    // Combinational helpers
    logic              seal_done;
    logic              no_corks;
    logic [CORK_W:0]   sec_sum;
    logic              add_ok;
    logic              rem_ok;
    logic [CORK_W-1:0] sec_post;
    logic              refill_go;
    logic [CORK_W-1:0] refill_room;
    logic [CORK_W-1:0] refill_n;

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    assign no_corks = (corks_q == '0) && (secondary_q == '0);

    always_comb begin
        state_d   = state_q;
        to_d      = to_q;
        seal_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // enable=0 is checked first so an empty machine that is
                // switched off rests in IDLE instead of bouncing through
                // ALARM.
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (no_corks) begin
                    state_d = ST_ALARM;
                end else if (corks_q != '0) begin
                    state_d = ST_MOVE;
                end
            end

            ST_MOVE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (no_corks) begin
                    state_d = ST_ALARM;
                end else if (pg) begin
                    state_d = ST_FILL;
                    to_d    = '0;
                end
            end

            ST_FILL: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (ch) begin
                    state_d = ST_SEAL;
                end else if (to_q == c_to_last) begin
                    // This is the FILL_TIMEOUT-th consecutive cycle without ch.
                    state_d = ST_ALARM;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            ST_SEAL: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (cq) begin
                    state_d   = ST_MOVE;
                    seal_done = 1'b1;
                end
            end

            ST_ALARM: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Registered outputs. They are decoded from the current state, so they
    // follow a state change one cycle later.
    //------------------------------------------------------------------------
    always_comb begin
        m_d      = (state_q == ST_MOVE);
        ev_d     = (state_q == ST_FILL);
        ve_d     = (state_q == ST_SEAL);
        al_d     = (state_q == ST_ALARM);
        estado_d = state_q;
    end

    //------------------------------------------------------------------------
    // Bottle / dozen counting
    //------------------------------------------------------------------------
    always_comb begin
        dozens_d     = dozens_q;
        tens_d       = tens_q;
        dozen_done_d = 1'b0;

        if (seal_done) begin
            if (dozens_q == c_dozen_last) begin
                dozens_d     = '0;
                dozen_done_d = 1'b1;
                tens_d       = (tens_q == c_tens_last) ? 4'd0 : tens_q + 4'd1;
            end else begin
                dozens_d = dozens_q + 4'd1;
            end
        end
    end

    //------------------------------------------------------------------------
    // Cork storage
    // The manual operation on the secondary buffer is resolved first.
    // Any auto-refill is then sized from the post-load secondary level.
    // Because of this, both levels stay within 0..CORK_MAX even when the
    // two happen in the same cycle.
    //------------------------------------------------------------------------
    assign sec_sum = {1'b0, secondary_q} + {1'b0, load_qty};
    assign add_ok  = (sec_sum <= c_cork_max_ext);
    assign rem_ok  = (load_qty <= secondary_q);

    always_comb begin
        sec_post      = secondary_q;
        load_reject_d = 1'b0;

        if (load_req) begin
            if (load_dir) begin
                if (add_ok) begin
                    sec_post = sec_sum[CORK_W-1:0];
                end else begin
                    load_reject_d = 1'b1;
                end
            end else begin
                if (rem_ok) begin
                    sec_post = secondary_q - load_qty;
                end else begin
                    load_reject_d = 1'b1;
                end
            end
        end
    end

    // The refill never runs in SEAL. That is the only state in which the
    // seal decrement can happen, so after a decrement the refill is looked
    // at again on the following cycle.
    assign refill_go   = (state_q != ST_SEAL) && (corks_q < c_cork_min) &&
                         (sec_post != '0);
    assign refill_room = c_cork_max - corks_q;

    always_comb begin
        refill_n = c_refill_qty;
        if (sec_post < refill_n) begin
            refill_n = sec_post;
        end
        if (refill_room < refill_n) begin
            refill_n = refill_room;
        end
    end

    always_comb begin
        corks_d     = corks_q;
        secondary_d = sec_post;

        if (seal_done) begin
            // SEAL is only reachable with corks available. The guard keeps
            // the counter from wrapping if that ever stops being true.
            corks_d = (corks_q != '0) ? corks_q - CORK_W'(1) : '0;
        end else if (refill_go) begin
            corks_d     = corks_q + refill_n;
            secondary_d = sec_post - refill_n;
        end
    end

    //------------------------------------------------------------------------
    // Registers
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= ST_IDLE;
            to_q          <= '0;
            corks_q       <= '0;
            secondary_q   <= '0;
            dozens_q      <= '0;
            tens_q        <= '0;
            dozen_done_q  <= 1'b0;
            load_reject_q <= 1'b0;
            m_q           <= 1'b0;
            ev_q          <= 1'b0;
            ve_q          <= 1'b0;
            al_q          <= 1'b0;
            estado_q      <= '0;
        end else begin
            state_q       <= state_d;
            to_q          <= to_d;
            corks_q       <= corks_d;
            secondary_q   <= secondary_d;
            dozens_q      <= dozens_d;
            tens_q        <= tens_d;
            dozen_done_q  <= dozen_done_d;
            load_reject_q <= load_reject_d;
            m_q           <= m_d;
            ev_q          <= ev_d;
            ve_q          <= ve_d;
            al_q          <= al_d;
            estado_q      <= estado_d;
        end
    end

    //------------------------------------------------------------------------
    // Output mapping
    //------------------------------------------------------------------------
    assign m           = m_q;
    assign ev          = ev_q;
    assign ve          = ve_q;
    assign al          = al_q;
    assign estado      = estado_q;
    assign corks       = corks_q;
    assign secondary   = secondary_q;
    assign dozens      = dozens_q;
    assign tens_dozens = tens_q;
    assign dozen_done  = dozen_done_q;
    assign load_reject = load_reject_q;

endmodule
`default_nettype wire

// File: tb/tb_controle_envase_parametrizado.sv
`default_nettype none
//============================================================================
// Module   : tb_controle_envase_parametrizado
// Purpose  : Self-checking bench for controle_envase_parametrizado.
//            Expected values are queued when stimulus is applied and are
//            popped and compared when the outputs are sampled.
// Revision : 1.0 - initial release
//============================================================================
module tb_controle_envase_parametrizado;

    localparam int CORK_W = 7;

    localparam int SEL_ESTADO = 0;
    localparam int SEL_M      = 1;
    localparam int SEL_EV     = 2;
    localparam int SEL_VE     = 3;
    localparam int SEL_AL     = 4;
    localparam int SEL_CORKS  = 5;
    localparam int SEL_SEC    = 6;
    localparam int SEL_DOZ    = 7;
    localparam int SEL_TENS   = 8;
    localparam int SEL_DDONE  = 9;
    localparam int SEL_REJ    = 10;

    logic              clk = 1'b0;
    logic              clr;
    logic              enable;
    logic              pg;
    logic              ch;
    logic              cq;
    logic              load_req;
    logic              load_dir;
    logic [CORK_W-1:0] load_qty;
    logic              m;
    logic              ev;
    logic              ve;
    logic              al;
    logic [2:0]        estado;
    logic [CORK_W-1:0] corks;
    logic [CORK_W-1:0] secondary;
    logic [3:0]        dozens;
    logic [3:0]        tens_dozens;
    logic              dozen_done;
    logic              load_reject;

    always #5 clk = ~clk;

    controle_envase_parametrizado #(
        .CORK_W       (7),
        .CORK_MAX     (99),
        .CORK_MIN     (5),
        .REFILL_QTY   (15),
        .DOZEN_WRAP   (10),
        .TO_W         (8),
        .FILL_TIMEOUT (200)
    ) u_dut (
        .clk         (clk),
        .clr         (clr),
        .enable      (enable),
        .pg          (pg),
        .ch          (ch),
        .cq          (cq),
        .load_req    (load_req),
        .load_dir    (load_dir),
        .load_qty    (load_qty),
        .m           (m),
        .ev          (ev),
        .ve          (ve),
        .al          (al),
        .estado      (estado),
        .corks       (corks),
        .secondary   (secondary),
        .dozens      (dozens),
        .tens_dozens (tens_dozens),
        .dozen_done  (dozen_done),
        .load_reject (load_reject)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string tag;
        int    sel;
        int    want;
    } exp_t;

    exp_t sb[$];

    task automatic chk_val(input string tag, input int obs, input int want);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic int observe(input int sel);
        case (sel)
            SEL_ESTADO: observe = int'(estado);
            SEL_M:      observe = int'(m);
            SEL_EV:     observe = int'(ev);
            SEL_VE:     observe = int'(ve);
            SEL_AL:     observe = int'(al);
            SEL_CORKS:  observe = int'(corks);
            SEL_SEC:    observe = int'(secondary);
            SEL_DOZ:    observe = int'(dozens);
            SEL_TENS:   observe = int'(tens_dozens);
            SEL_DDONE:  observe = int'(dozen_done);
            SEL_REJ:    observe = int'(load_reject);
            default:    observe = -1;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sel, input int want);
        sb.push_back('{tag: tag, sel: sel, want: want});
    endtask

    task automatic score();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk_val(e.tag, observe(e.sel), e.want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for an output to reach a value. An expired bound is
    // reported as a failed comparison.
    task automatic wait_for(input int sel, input int val, input string tag);
        int k;
        k = 0;
        while (observe(sel) != val && k < 50) begin
            tick();
            k++;
        end
        if (observe(sel) != val) begin
            chk_val(tag, observe(sel), val);
        end
    endtask

    task automatic do_reset();
        clr      = 1'b1;
        enable   = 1'b0;
        pg       = 1'b0;
        ch       = 1'b0;
        cq       = 1'b0;
        load_req = 1'b0;
        load_dir = 1'b0;
        load_qty = '0;
        tick();
        clr = 1'b0;
    endtask

    task automatic manual(input logic dir, input int qty);
        load_req = 1'b1;
        load_dir = dir;
        load_qty = CORK_W'(qty);
        tick();
        load_req = 1'b0;
    endtask

    task automatic bottle();
        wait_for(SEL_M, 1, "wait_m");
        pg = 1'b1;
        tick();
        pg = 1'b0;
        wait_for(SEL_EV, 1, "wait_ev");
        ch = 1'b1;
        tick();
        ch = 1'b0;
        wait_for(SEL_VE, 1, "wait_ve");
        cq = 1'b1;
        tick();
        cq = 1'b0;
    endtask

    task automatic push_all_zero(input string tag);
        push_exp({tag, "_estado"}, SEL_ESTADO, 0);
        push_exp({tag, "_m"},      SEL_M,      0);
        push_exp({tag, "_ev"},     SEL_EV,     0);
        push_exp({tag, "_ve"},     SEL_VE,     0);
        push_exp({tag, "_al"},     SEL_AL,     0);
        push_exp({tag, "_corks"},  SEL_CORKS,  0);
        push_exp({tag, "_sec"},    SEL_SEC,    0);
        push_exp({tag, "_doz"},    SEL_DOZ,    0);
        push_exp({tag, "_tens"},   SEL_TENS,   0);
        push_exp({tag, "_ddone"},  SEL_DDONE,  0);
        push_exp({tag, "_rej"},    SEL_REJ,    0);
    endtask

    initial begin
        // Reset state
        do_reset();
        push_all_zero("rst");
        score();

        // Load 30 -> refill 15/15, then one full bottle cycle
        manual(1'b1, 30);
        push_exp("ld30_corks", SEL_CORKS, 15);
        push_exp("ld30_sec",   SEL_SEC,   15);
        score();
        enable = 1'b1;
        wait_for(SEL_M, 1, "wait_move");
        push_exp("move_estado", SEL_ESTADO, 1);
        push_exp("move_ev",     SEL_EV,     0);
        score();
        pg = 1'b1;
        tick();
        pg = 1'b0;
        wait_for(SEL_EV, 1, "wait_fill");
        push_exp("fill_estado", SEL_ESTADO, 2);
        push_exp("fill_m",      SEL_M,      0);
        score();
        ch = 1'b1;
        tick();
        ch = 1'b0;
        wait_for(SEL_VE, 1, "wait_seal");
        push_exp("seal_estado", SEL_ESTADO, 3);
        push_exp("seal_ev",     SEL_EV,     0);
        score();
        cq = 1'b1;
        tick();
        cq = 1'b0;
        push_exp("b1_corks", SEL_CORKS, 14);
        push_exp("b1_doz",   SEL_DOZ,   1);
        push_exp("b1_sec",   SEL_SEC,   15);
        score();

        // Reset in the middle of FILL
        wait_for(SEL_M, 1, "wait_m2");
        pg = 1'b1;
        tick();
        pg = 1'b0;
        wait_for(SEL_EV, 1, "wait_fill2");
        do_reset();
        push_all_zero("clr_fill");
        score();

        // Empty machine enabled -> ALARM, disabled -> IDLE
        enable = 1'b1;
        tick();
        tick();
        push_exp("empty_al",     SEL_AL,     1);
        push_exp("empty_estado", SEL_ESTADO, 4);
        push_exp("empty_m",      SEL_M,      0);
        score();
        enable = 1'b0;
        tick();
        tick();
        push_exp("empty_off_al",     SEL_AL,     0);
        push_exp("empty_off_estado", SEL_ESTADO, 0);
        score();

        // 120 bottles: tens_dozens walks 0..9 and wraps on the 120th
        do_reset();
        manual(1'b1, 99);
        push_exp("ld99_corks", SEL_CORKS, 15);
        push_exp("ld99_sec",   SEL_SEC,   84);
        score();
        enable = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            if (i == 41 || i == 81) begin
                manual(1'b1, 40);
            end
            bottle();
            push_exp("run_doz",   SEL_DOZ,   i % 12);
            push_exp("run_tens",  SEL_TENS,  (i / 12) % 10);
            push_exp("run_ddone", SEL_DDONE, (i % 12 == 0) ? 1 : 0);
            score();
        end
        tick();
        push_exp("wrap_ddone_clear", SEL_DDONE, 0);
        push_exp("wrap_tens",        SEL_TENS,  0);
        score();

        // Fill timeout: 200 cycles in FILL without ch
        wait_for(SEL_M, 1, "wait_m_to");
        pg = 1'b1;
        tick();
        pg = 1'b0;
        repeat (199) tick();
        push_exp("to_pre_estado", SEL_ESTADO, 2);
        push_exp("to_pre_al",     SEL_AL,     0);
        score();
        tick();
        tick();
        push_exp("to_al",     SEL_AL,     1);
        push_exp("to_estado", SEL_ESTADO, 4);
        push_exp("to_m",      SEL_M,      0);
        push_exp("to_ev",     SEL_EV,     0);
        score();
        enable = 1'b0;
        tick();
        tick();
        push_exp("to_off_al",     SEL_AL,     0);
        push_exp("to_off_estado", SEL_ESTADO, 0);
        score();

        // Manual load accept/reject boundaries
        do_reset();
        manual(1'b1, 99);
        manual(1'b1, 6);
        push_exp("ml90_sec",   SEL_SEC,   90);
        push_exp("ml90_corks", SEL_CORKS, 15);
        push_exp("ml90_rej",   SEL_REJ,   0);
        score();
        manual(1'b1, 10);
        push_exp("add10_rej", SEL_REJ, 1);
        push_exp("add10_sec", SEL_SEC, 90);
        score();
        tick();
        push_exp("rej_pulse_end", SEL_REJ, 0);
        score();
        manual(1'b1, 9);
        push_exp("add9_sec", SEL_SEC, 99);
        push_exp("add9_rej", SEL_REJ, 0);
        score();
        manual(1'b0, 9);
        push_exp("rem9_sec", SEL_SEC, 90);
        score();
        manual(1'b0, 91);
        push_exp("rem91_rej", SEL_REJ, 1);
        push_exp("rem91_sec", SEL_SEC, 90);
        score();
        manual(1'b0, 90);
        push_exp("rem90_sec", SEL_SEC, 0);
        push_exp("rem90_rej", SEL_REJ, 0);
        score();
        manual(1'b1, 127);
        push_exp("add127_rej", SEL_REJ, 1);
        push_exp("add127_sec", SEL_SEC, 0);
        score();

        // Manual load and auto-refill in the same cycle
        do_reset();
        manual(1'b1, 8);
        push_exp("ld8_corks", SEL_CORKS, 8);
        push_exp("ld8_sec",   SEL_SEC,   0);
        score();
        enable = 1'b1;
        repeat (4) bottle();
        push_exp("b4_corks", SEL_CORKS, 4);
        score();
        wait_for(SEL_M, 1, "wait_m5");
        pg = 1'b1;
        tick();
        pg = 1'b0;
        wait_for(SEL_EV, 1, "wait_ev5");
        ch = 1'b1;
        tick();
        ch = 1'b0;
        wait_for(SEL_VE, 1, "wait_ve5");
        cq       = 1'b1;
        load_req = 1'b1;
        load_dir = 1'b1;
        load_qty = CORK_W'(2);
        tick();
        cq       = 1'b0;
        push_exp("sim_pre_corks", SEL_CORKS, 3);
        push_exp("sim_pre_sec",   SEL_SEC,   2);
        push_exp("sim_pre_doz",   SEL_DOZ,   5);
        score();
        load_qty = CORK_W'(20);
        tick();
        load_req = 1'b0;
        push_exp("sim_corks", SEL_CORKS, 18);
        push_exp("sim_sec",   SEL_SEC,   7);
        score();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
